// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit scheduler.
package uart_pkg;

    localparam int unsigned ByteW          = 8;
    localparam int unsigned DefaultTimeout = 200000;
    localparam int unsigned DefaultGap     = 16;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StLoad = 2'b01,
        StWait = 2'b10,
        StGap  = 2'b11
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning from ptr upward, modulo NUM_REQ.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IdxW-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IdxW-1:0]    idx,
    output logic               any_valid
);

    logic [IdxW-1:0] pos;

    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        pos       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = IdxW'((i + 32'(ptr)) % NUM_REQ);
            if (!any_valid && req[pos]) begin
                grant[pos] = 1'b1;
                idx        = pos;
                any_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one byte-serial UART transmitter among NUM_REQ sources,
// with a post-frame idle gap and a watchdog on the transmitter's done pulse.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned GAP_CYCLES = DefaultGap,
    parameter int unsigned TIMEOUT    = DefaultTimeout
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [ByteW*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [ByteW-1:0]         tx_data,
    output logic                     tx_start,
    input  logic                     tx_done,
    output logic                     busy,
    output logic [2:0]               grant_id,
    output logic                     err_timeout,
    output logic [15:0]              frames_sent
);

    localparam int unsigned IdxW  = $clog2(NUM_REQ);
    localparam int unsigned WdogW = $clog2(TIMEOUT);
    // A zero-cycle gap still needs a legal (unused) counter width.
    localparam int unsigned GapW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [IdxW-1:0]     grant_q, grant_d;
    logic [ByteW-1:0]    tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic                tx_start_q, tx_start_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [15:0]         frames_q, frames_d;
    logic [WdogW-1:0]    wdog_q, wdog_d;
    logic [GapW-1:0]     gap_q, gap_d;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [IdxW-1:0]     arb_idx;
    logic                arb_any;
    logic [ByteW-1:0]    req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[g*ByteW +: ByteW];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IdxW    (IdxW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .idx       (arb_idx),
        .any_valid (arb_any)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        tx_data_d   = tx_data_q;
        req_ready_d = '0;
        tx_start_d  = 1'b0;
        err_d       = 1'b0;
        frames_d    = frames_q;
        wdog_d      = wdog_q;
        gap_d       = gap_q;

        unique case (state_q)
            StIdle: begin
                // Ready/start are registered here so they are high during the LOAD cycle.
                if (arb_any) begin
                    state_d     = StLoad;
                    grant_d     = arb_idx;
                    tx_data_d   = req_bytes[arb_idx];
                    req_ready_d = arb_grant;
                    tx_start_d  = 1'b1;
                end
            end
            StLoad: begin
                state_d = StWait;
                wdog_d  = '0;
                ptr_d   = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
            StWait: begin
                wdog_d = wdog_q + 1'b1;
                if (tx_done) begin
                    frames_d = frames_q + 16'd1;
                    if (GAP_CYCLES > 0) begin
                        state_d = StGap;
                        gap_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (wdog_q == WdogW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StGap: begin
                if (gap_q == GapW'(GAP_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            grant_q     <= '0;
            tx_data_q   <= '0;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            frames_q    <= '0;
            wdog_q      <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            tx_data_q   <= tx_data_d;
            req_ready_q <= req_ready_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            frames_q    <= frames_d;
            wdog_q      <= wdog_d;
            gap_q       <= gap_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign busy        = busy_q;
    assign grant_id    = 3'(grant_q);
    assign err_timeout = err_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench: instance a uses a 16-cycle gap, instance b has no gap and an 8-cycle watchdog.
module tb_uart_tx_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic [3:0]  req_valid_a = '0, req_valid_b = '0;
    logic [31:0] req_data_a = '0, req_data_b = '0;
    logic        tx_done_a = 1'b0, tx_done_b = 1'b0;
    logic [3:0]  req_ready_a, req_ready_b;
    logic [7:0]  tx_data_a, tx_data_b;
    logic        tx_start_a, tx_start_b, busy_a, busy_b, err_a, err_b;
    logic [2:0]  grant_id_a, grant_id_b;
    logic [15:0] frames_a, frames_b;

    uart_tx_sched #(.NUM_REQ(4), .GAP_CYCLES(16), .TIMEOUT(200000)) u_dut_a (
        .clk(clk), .rst(rst_a), .req_valid(req_valid_a), .req_data(req_data_a),
        .req_ready(req_ready_a), .tx_data(tx_data_a), .tx_start(tx_start_a),
        .tx_done(tx_done_a), .busy(busy_a), .grant_id(grant_id_a),
        .err_timeout(err_a), .frames_sent(frames_a)
    );

    uart_tx_sched #(.NUM_REQ(4), .GAP_CYCLES(0), .TIMEOUT(8)) u_dut_b (
        .clk(clk), .rst(rst_b), .req_valid(req_valid_b), .req_data(req_data_b),
        .req_ready(req_ready_b), .tx_data(tx_data_b), .tx_start(tx_start_b),
        .tx_done(tx_done_b), .busy(busy_b), .grant_id(grant_id_b),
        .err_timeout(err_b), .frames_sent(frames_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start_a(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            tick();
            if (tx_start_a === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic pulse_done_a();
        tx_done_a = 1'b1;
        tick();
        tx_done_a = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        total++; if (req_ready_a !== 4'b0000) begin bad++; $display("FAIL rst_ready got %b want 0000", req_ready_a); end
        total++; if (tx_start_a !== 1'b0) begin bad++; $display("FAIL rst_start got %b want 0", tx_start_a); end
        total++; if (tx_data_a !== 8'h00) begin bad++; $display("FAIL rst_data got %h want 00", tx_data_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy_a); end
        total++; if (grant_id_a !== 3'd0) begin bad++; $display("FAIL rst_grant got %0d want 0", grant_id_a); end
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL rst_err got %b want 0", err_a); end
        total++; if (frames_a !== 16'd0) begin bad++; $display("FAIL rst_frames got %0d want 0", frames_a); end
        total++; if ({busy_b, tx_start_b, err_b} !== 3'b000) begin bad++; $display("FAIL rst_b_flags got %b want 000", {busy_b, tx_start_b, err_b}); end
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL idle_busy got %b want 0", busy_a); end
    endtask

    task automatic test_single();
        req_data_a  = 32'h13A5_1110;
        req_valid_a = 4'b0100;
        tick();
        total++; if (req_ready_a !== 4'b0100) begin bad++; $display("FAIL single_ready got %b want 0100", req_ready_a); end
        total++; if (tx_start_a !== 1'b1) begin bad++; $display("FAIL single_start got %b want 1", tx_start_a); end
        total++; if (tx_data_a !== 8'hA5) begin bad++; $display("FAIL single_data got %h want a5", tx_data_a); end
        total++; if (grant_id_a !== 3'd2) begin bad++; $display("FAIL single_grant got %0d want 2", grant_id_a); end
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL single_busy got %b want 1", busy_a); end
        req_valid_a = 4'b0000;
        tick();
        total++; if ({req_ready_a, tx_start_a} !== 5'b00000) begin bad++; $display("FAIL single_pulse got %b want 00000", {req_ready_a, tx_start_a}); end
        repeat (9) tick();
        pulse_done_a();
        total++; if (frames_a !== 16'd1) begin bad++; $display("FAIL single_frames got %0d want 1", frames_a); end
        repeat (15) tick();
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL single_gap_busy got %b want 1", busy_a); end
        total++; if (tx_data_a !== 8'hA5) begin bad++; $display("FAIL single_data_hold got %h want a5", tx_data_a); end
        tick();
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL single_gap_end got %b want 0", busy_a); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ready;
        logic [7:0] exp_data;
        bit         seen;
        rst_a = 1'b0;
        #2;
        rst_a = 1'b1;
        req_data_a  = 32'h1312_1110;
        req_valid_a = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_ready = 4'(1 << (g % 4));
            exp_data  = 8'h10 + 8'(g % 4);
            seen = 1'b0;
            for (int n = 0; n < 40 && !seen; n++) begin
                tick();
                if ($countones(req_ready_a) > 1) begin
                    total++; bad++;
                    $display("FAIL rr_onehot got %b want at most one bit", req_ready_a);
                end
                if (tx_start_a === 1'b1) seen = 1'b1;
            end
            total++; if (!seen) begin bad++; $display("FAIL rr_start got timeout want start %0d", g); end
            total++; if (grant_id_a !== 3'(g % 4)) begin bad++; $display("FAIL rr_grant got %0d want %0d", grant_id_a, g % 4); end
            total++; if (req_ready_a !== exp_ready) begin bad++; $display("FAIL rr_ready got %b want %b", req_ready_a, exp_ready); end
            total++; if (tx_data_a !== exp_data) begin bad++; $display("FAIL rr_data got %h want %h", tx_data_a, exp_data); end
            tick();
            total++; if (req_ready_a !== 4'b0000) begin bad++; $display("FAIL rr_ready_pulse got %b want 0000", req_ready_a); end
            pulse_done_a();
        end
        req_valid_a = 4'b0000;
    endtask

    task automatic test_fairness();
        bit seen;
        rst_a = 1'b0;
        #2;
        rst_a = 1'b1;
        req_data_a  = 32'h4433_2211;
        req_valid_a = 4'b0001;
        wait_start_a(seen);
        total++; if (!seen || grant_id_a !== 3'd0) begin bad++; $display("FAIL fair_first got %0d seen=%0d want 0", grant_id_a, seen); end
        req_valid_a = 4'b1001;
        tick();
        pulse_done_a();
        wait_start_a(seen);
        total++; if (!seen || grant_id_a !== 3'd3) begin bad++; $display("FAIL fair_skip got %0d seen=%0d want 3", grant_id_a, seen); end
        total++; if (tx_data_a !== 8'h44) begin bad++; $display("FAIL fair_data got %h want 44", tx_data_a); end
        req_valid_a = 4'b0001;
        tick();
        pulse_done_a();
        wait_start_a(seen);
        total++; if (!seen || grant_id_a !== 3'd0) begin bad++; $display("FAIL fair_wrap got %0d seen=%0d want 0", grant_id_a, seen); end
        req_valid_a = 4'b0000;
        tick();
        pulse_done_a();
    endtask

    task automatic test_spurious_gap();
        bit seen;
        repeat (20) tick();
        req_valid_a = 4'b0010;
        wait_start_a(seen);
        total++; if (!seen || grant_id_a !== 3'd1) begin bad++; $display("FAIL sgap_grant got %0d seen=%0d want 1", grant_id_a, seen); end
        req_valid_a = 4'b0000;
        tick();
        pulse_done_a();
        repeat (4) tick();
        pulse_done_a();
        total++; if (frames_a !== 16'd4) begin bad++; $display("FAIL sgap_frames got %0d want 4", frames_a); end
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL sgap_busy got %b want 1", busy_a); end
        repeat (10) tick();
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL sgap_len got %b want 1", busy_a); end
        tick();
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL sgap_end got %b want 0", busy_a); end
    endtask

    task automatic test_watchdog();
        int errs;
        req_data_b  = 32'h4433_2211;
        req_valid_b = 4'b0010;
        tick();
        total++; if (tx_start_b !== 1'b1) begin bad++; $display("FAIL wd_start got %b want 1", tx_start_b); end
        req_valid_b = 4'b0000;
        errs = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (err_b === 1'b1) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL wd_early got %0d want 0", errs); end
        tick();
        total++; if (err_b !== 1'b1) begin bad++; $display("FAIL wd_err got %b want 1", err_b); end
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL wd_idle got %b want 0", busy_b); end
        total++; if (frames_b !== 16'd0) begin bad++; $display("FAIL wd_frames got %0d want 0", frames_b); end
        tick();
        total++; if (err_b !== 1'b0) begin bad++; $display("FAIL wd_pulse got %b want 0", err_b); end

        req_valid_b = 4'b0010;
        tick();
        total++; if (tx_start_b !== 1'b1 || grant_id_b !== 3'd1) begin bad++; $display("FAIL wd2_start got %b/%0d want 1/1", tx_start_b, grant_id_b); end
        req_valid_b = 4'b0000;
        repeat (8) tick();
        tx_done_b   = 1'b1;
        req_valid_b = 4'b1000;
        tick();
        tx_done_b = 1'b0;
        total++; if (err_b !== 1'b0) begin bad++; $display("FAIL wd2_err got %b want 0", err_b); end
        total++; if (frames_b !== 16'd1) begin bad++; $display("FAIL wd2_frames got %0d want 1", frames_b); end
        total++; if ({busy_b, tx_start_b} !== 2'b00) begin bad++; $display("FAIL gap0_idle got %b want 00", {busy_b, tx_start_b}); end
        tick();
        total++; if (tx_start_b !== 1'b1 || grant_id_b !== 3'd3) begin bad++; $display("FAIL gap0_start got %b/%0d want 1/3", tx_start_b, grant_id_b); end
        total++; if (tx_data_b !== 8'h44) begin bad++; $display("FAIL gap0_data got %h want 44", tx_data_b); end
        req_valid_b = 4'b0000;
        tick();
        tx_done_b = 1'b1;
        tick();
        tx_done_b = 1'b0;
        total++; if (frames_b !== 16'd2) begin bad++; $display("FAIL gap0_frames got %0d want 2", frames_b); end
        tx_done_b = 1'b1;
        tick();
        tx_done_b = 1'b0;
        tick();
        total++; if (frames_b !== 16'd2 || busy_b !== 1'b0) begin bad++; $display("FAIL sidle got %0d/%b want 2/0", frames_b, busy_b); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        req_data_a  = 32'h1312_1177;
        req_valid_a = 4'b0001;
        wait_start_a(seen);
        total++; if (!seen || tx_data_a !== 8'h77) begin bad++; $display("FAIL rmid_load got %h seen=%0d want 77", tx_data_a, seen); end
        req_valid_a = 4'b0000;
        tick();
        tick();
        #2;
        rst_a = 1'b0;
        #1;
        total++; if ({busy_a, tx_start_a, err_a, req_ready_a} !== 7'b0) begin bad++; $display("FAIL rmid_flags got %b want 0000000", {busy_a, tx_start_a, err_a, req_ready_a}); end
        total++; if ({tx_data_a, grant_id_a, frames_a} !== 27'b0) begin bad++; $display("FAIL rmid_regs got %h want 0", {tx_data_a, grant_id_a, frames_a}); end
        tick();
        #1;
        rst_a = 1'b1;
        tick();
        total++; if ({busy_a, tx_start_a, req_ready_a} !== 6'b0) begin bad++; $display("FAIL rmid_glitch got %b want 000000", {busy_a, tx_start_a, req_ready_a}); end
        req_valid_a = 4'b0101;
        tick();
        total++; if (grant_id_a !== 3'd0 || tx_start_a !== 1'b1) begin bad++; $display("FAIL rmid_ptr got %0d/%b want 0/1", grant_id_a, tx_start_a); end
        req_valid_a = 4'b0000;
        tick();
        #2;
        rst_a = 1'b0;
        #2;
        rst_a = 1'b1;
        req_data_a  = 32'h13A5_1110;
        req_valid_a = 4'b0100;
        tick();
        total++; if (grant_id_a !== 3'd2 || req_ready_a !== 4'b0100) begin bad++; $display("FAIL rmid_req2 got %0d/%b want 2/0100", grant_id_a, req_ready_a); end
        req_valid_a = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got stuck want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_spurious_gap();
        test_watchdog();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
